// File: rtl/mem_arb_pkg.sv
// Shared encodings and latency limits for the data-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = 4;

    // Counter preload: LATENCY-1, clamped into the legal latency range.
    function automatic logic [CNT_W-1:0] lat_load(input int lat);
        int l;
        l = lat;
        if (l < LATENCY_MIN) l = LATENCY_MIN;
        if (l > LATENCY_MAX) l = LATENCY_MAX;
        return CNT_W'(l - 1);
    endfunction

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter with zero flag; times the memory read latency.
module mem_lat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported data memory between fetch and memory stages.
// Optional macro MEM_PORT_ARB_RR_EN: round-robin tie-break via a last-owner register.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] mem_rdata,
    output logic          mem_ready,
    output logic          mem_err,
    output logic          stall_f,
    output logic          stall_m,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    owner_t           r_owner;
    owner_t           w_grant_owner;
    owner_t           w_pick;
    logic             r_we;
    logic             r_misalign;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_wdata;
    logic             w_grant;
    logic             w_grant_mis;
    logic             w_cnt_load;
    logic             w_cnt_dec;
    logic             w_cnt_zero;
    logic             w_capture;
    logic             w_err_resp;
    logic [CNT_W-1:0] w_cnt_value;

`ifdef MEM_PORT_ARB_RR_EN
    owner_t r_last_owner;

    // On a tie, whichever requester was not served last wins.
    assign w_pick = (mem_req && if_req) ? ((r_last_owner == OWN_IF) ? OWN_MEM : OWN_IF)
                                        : (mem_req ? OWN_MEM : OWN_IF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_owner <= OWN_IF;
        end else if (w_grant) begin
            r_last_owner <= w_grant_owner;
        end
    end
`else
    assign w_pick = mem_req ? OWN_MEM : OWN_IF;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_grant       = 1'b0;
        w_grant_owner = OWN_IF;
        w_cnt_load    = 1'b0;
        w_cnt_dec     = 1'b0;
        w_capture     = 1'b0;
        w_err_resp    = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_req || if_req) begin
                    w_grant       = 1'b1;
                    w_grant_owner = w_pick;
                    w_state_next  = ISSUE;
                end
            end
            ISSUE: begin
                w_cnt_load = 1'b1;
                // A misaligned store/load never touches the RAM and errors out immediately.
                if ((r_owner == OWN_MEM) && r_misalign) begin
                    w_err_resp   = 1'b1;
                    w_state_next = RESP;
                end else begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (w_cnt_zero) begin
                    w_capture    = 1'b1;
                    w_state_next = RESP;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_grant_mis = (w_grant_owner == OWN_MEM) && is_misaligned(mem_addr[1:0]);

    mem_lat_counter #(
        .W(CNT_W)
    ) u_lat_counter (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_cnt_load),
        .i_load_val (lat_load(LATENCY)),
        .i_dec      (w_cnt_dec),
        .o_count    (w_cnt_value),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner    <= OWN_IF;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_misalign <= 1'b0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
            if_ready   <= 1'b0;
            mem_ready  <= 1'b0;
            mem_err    <= 1'b0;
        end else begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            if (w_grant) begin
                r_owner    <= w_grant_owner;
                r_misalign <= w_grant_mis;
                if (w_grant_owner == OWN_MEM) begin
                    r_addr  <= mem_addr;
                    r_wdata <= mem_wdata;
                    r_we    <= mem_we;
                end else begin
                    r_addr  <= if_addr;
                    r_wdata <= '0;
                    r_we    <= 1'b0;
                end
                // The strobe is registered here so it is high exactly for the ISSUE cycle.
                ram_en <= ~w_grant_mis;
                ram_we <= (w_grant_owner == OWN_MEM) && mem_we && ~w_grant_mis;
            end
            if (w_capture) begin
                if (r_owner == OWN_IF) begin
                    if_rdata <= ram_rdata;
                    if_ready <= 1'b1;
                end else begin
                    if (!r_we) begin
                        mem_rdata <= ram_rdata;
                    end
                    mem_ready <= 1'b1;
                end
            end
            if (w_err_resp) begin
                mem_ready <= 1'b1;
                mem_err   <= 1'b1;
            end
        end
    end

    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;

    assign stall_f = if_req & ~if_ready;
    assign stall_m = mem_req & ~mem_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench: one LATENCY=2 instance and one LATENCY=1 instance.
module tb_mem_port_arbiter;

    logic clk;
    logic reset;

    logic        a_if_req, a_mem_req, a_mem_we;
    logic [31:0] a_if_addr, a_mem_addr, a_mem_wdata;
    logic [31:0] a_if_rdata, a_mem_rdata, a_ram_addr, a_ram_wdata, a_ram_rdata;
    logic        a_if_ready, a_mem_ready, a_mem_err, a_stall_f, a_stall_m, a_ram_en, a_ram_we;

    logic        b_if_req, b_mem_req, b_mem_we;
    logic [31:0] b_if_addr, b_mem_addr, b_mem_wdata;
    logic [31:0] b_if_rdata, b_mem_rdata, b_ram_addr, b_ram_wdata, b_ram_rdata;
    logic        b_if_ready, b_mem_ready, b_mem_err, b_stall_f, b_stall_m, b_ram_en, b_ram_we;

    int checks;
    int errors;

    mem_port_arbiter #(.LATENCY(2), .AW(32), .DW(32)) u_dut_a (
        .clk(clk), .reset(reset),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ready(a_if_ready),
        .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata), .mem_ready(a_mem_ready), .mem_err(a_mem_err),
        .stall_f(a_stall_f), .stall_m(a_stall_m),
        .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata),
        .ram_rdata(a_ram_rdata)
    );

    mem_port_arbiter #(.LATENCY(1), .AW(32), .DW(32)) u_dut_b (
        .clk(clk), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .mem_ready(b_mem_ready), .mem_err(b_mem_err),
        .stall_f(b_stall_f), .stall_m(b_stall_m),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
        .ram_rdata(b_ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: read data returns LATENCY cycles after the strobe, marker otherwise.
    logic [31:0] ram_a [0:63];
    logic [31:0] pipe_a [0:1];
    logic [31:0] ram_b [0:63];
    logic [31:0] pipe_b;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) ram_a[i] <= 32'h0;
            ram_a[4]  <= 32'hDEADBEEF;
            ram_a[0]  <= 32'hCAFEF00D;
            pipe_a[0] <= 32'h0BAD0BAD;
            pipe_a[1] <= 32'h0BAD0BAD;
        end else begin
            if (a_ram_en && a_ram_we) ram_a[a_ram_addr[7:2]] <= a_ram_wdata;
            pipe_a[0] <= (a_ram_en && !a_ram_we) ? ram_a[a_ram_addr[7:2]] : 32'h0BAD0BAD;
            pipe_a[1] <= pipe_a[0];
        end
    end
    assign a_ram_rdata = pipe_a[1];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) ram_b[i] <= 32'h0;
            ram_b[1] <= 32'h00004444;
            pipe_b   <= 32'h0BAD0BAD;
        end else begin
            if (b_ram_en && b_ram_we) ram_b[b_ram_addr[7:2]] <= b_ram_wdata;
            pipe_b <= (b_ram_en && !b_ram_we) ? ram_b[b_ram_addr[7:2]] : 32'h0BAD0BAD;
        end
    end
    assign b_ram_rdata = pipe_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [7:0] grant_own;
    int         n_grants;
    logic [7:0] exp_own;

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        a_if_req = 0; a_mem_req = 0; a_mem_we = 0;
        a_if_addr = 0; a_mem_addr = 0; a_mem_wdata = 0;
        b_if_req = 0; b_mem_req = 0; b_mem_we = 0;
        b_if_addr = 0; b_mem_addr = 0; b_mem_wdata = 0;

        // Reset state
        step(); step();
        #1;
        chk("rst_ram_en", {31'b0, a_ram_en}, 32'd0);
        chk("rst_ram_we", {31'b0, a_ram_we}, 32'd0);
        chk("rst_ram_addr", a_ram_addr, 32'd0);
        chk("rst_ram_wdata", a_ram_wdata, 32'd0);
        chk("rst_if_rdata", a_if_rdata, 32'd0);
        chk("rst_mem_rdata", a_mem_rdata, 32'd0);
        chk("rst_readys", {29'b0, a_if_ready, a_mem_ready, a_mem_err}, 32'd0);
        step();
        reset = 1'b0;
        step();

        // 1: aligned MEM read at 0x10, LATENCY=2
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) step();
            if (c == 0) begin a_mem_req = 1; a_mem_we = 0; a_mem_addr = 32'h10; end
            if (c == 5) a_mem_req = 0;
            #1;
            chk($sformatf("rd_ram_en_c%0d", c), {31'b0, a_ram_en}, {31'b0, c == 1});
            chk($sformatf("rd_mem_ready_c%0d", c), {31'b0, a_mem_ready}, {31'b0, c == 4});
            chk($sformatf("rd_stall_m_c%0d", c), {31'b0, a_stall_m}, {31'b0, c <= 3});
            if (c == 1) begin
                chk("rd_ram_addr", a_ram_addr, 32'h10);
                chk("rd_ram_we", {31'b0, a_ram_we}, 32'd0);
            end
            if (c == 4) begin
                chk("rd_mem_rdata", a_mem_rdata, 32'hDEADBEEF);
                chk("rd_mem_err", {31'b0, a_mem_err}, 32'd0);
                chk("rd_if_ready", {31'b0, a_if_ready}, 32'd0);
            end
        end

        // 2: simultaneous IF read 0x0 and MEM write 0x20 -> MEM first
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) step();
            if (c == 0) begin
                a_if_req = 1; a_if_addr = 32'h0;
                a_mem_req = 1; a_mem_we = 1; a_mem_addr = 32'h20; a_mem_wdata = 32'h12345678;
            end
            if (c == 5) begin a_mem_req = 0; a_mem_we = 0; end
            if (c == 10) a_if_req = 0;
            #1;
            chk($sformatf("both_ram_en_c%0d", c), {31'b0, a_ram_en}, {31'b0, (c == 1) || (c == 6)});
            chk($sformatf("both_mem_ready_c%0d", c), {31'b0, a_mem_ready}, {31'b0, c == 4});
            chk($sformatf("both_if_ready_c%0d", c), {31'b0, a_if_ready}, {31'b0, c == 9});
            chk($sformatf("both_stall_f_c%0d", c), {31'b0, a_stall_f}, {31'b0, c <= 8});
            if (c == 1) begin
                chk("both_wr_we", {31'b0, a_ram_we}, 32'd1);
                chk("both_wr_addr", a_ram_addr, 32'h20);
                chk("both_wr_data", a_ram_wdata, 32'h12345678);
            end
            if (c == 6) begin
                chk("both_if_we", {31'b0, a_ram_we}, 32'd0);
                chk("both_if_addr", a_ram_addr, 32'h0);
            end
            if (c == 9) chk("both_if_rdata", a_if_rdata, 32'hCAFEF00D);
        end
        chk("both_ram_written", ram_a[8], 32'h12345678);

        // 3: both requests held across four accesses
        n_grants = 0;
        grant_own = 8'h0;
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) step();
            if (c == 0) begin
                a_if_req = 1; a_if_addr = 32'h40;
                a_mem_req = 1; a_mem_we = 0; a_mem_addr = 32'h80;
            end
            if (c == 20) begin a_if_req = 0; a_mem_req = 0; end
            #1;
            if (a_ram_en && n_grants < 8) begin
                grant_own[n_grants] = (a_ram_addr == 32'h80);
                n_grants++;
            end
        end
`ifdef MEM_PORT_ARB_RR_EN
        exp_own = 8'b0000_0101;
`else
        exp_own = 8'b0000_1111;
`endif
        chk("arb_grant_count", n_grants, 32'd4);
        chk("arb_grant_owners", {24'b0, grant_own}, {24'b0, exp_own});
        step(); step(); step(); step(); step(); step();

        // 4: misaligned MEM read 0x13
        for (int c = 0; c <= 3; c++) begin
            if (c > 0) step();
            if (c == 0) begin a_mem_req = 1; a_mem_we = 0; a_mem_addr = 32'h13; end
            if (c == 3) a_mem_req = 0;
            #1;
            chk($sformatf("mis_ram_en_c%0d", c), {31'b0, a_ram_en}, 32'd0);
            chk($sformatf("mis_mem_ready_c%0d", c), {31'b0, a_mem_ready}, {31'b0, c == 2});
            chk($sformatf("mis_mem_err_c%0d", c), {31'b0, a_mem_err}, {31'b0, c == 2});
        end

        // 5: reset during WAIT of a write, request held through reset
        for (int c = 0; c <= 2; c++) begin
            if (c > 0) step();
            if (c == 0) begin
                a_mem_req = 1; a_mem_we = 1; a_mem_addr = 32'h30; a_mem_wdata = 32'h55AA55AA;
            end
            #1;
            if (c == 1) chk("rstw_ram_en", {31'b0, a_ram_en}, 32'd1);
        end
        reset = 1'b1;
        #1;
        chk("rstw_ram_en_async", {31'b0, a_ram_en}, 32'd0);
        chk("rstw_ram_addr_async", a_ram_addr, 32'd0);
        chk("rstw_ram_wdata_async", a_ram_wdata, 32'd0);
        chk("rstw_ready_async", {30'b0, a_mem_ready, a_if_ready}, 32'd0);
        step();
        #1;
        chk("rstw_ready_held", {31'b0, a_mem_ready}, 32'd0);
        step();
        reset = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) step();
            if (c == 5) begin a_mem_req = 0; a_mem_we = 0; end
            #1;
            chk($sformatf("rstw_ram_en_c%0d", c), {31'b0, a_ram_en}, {31'b0, c == 1});
            chk($sformatf("rstw_mem_ready_c%0d", c), {31'b0, a_mem_ready}, {31'b0, c == 4});
            if (c == 1) chk("rstw_ram_we", {31'b0, a_ram_we}, 32'd1);
        end

        // 6: LATENCY=1 instance, IF read 0x4
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) step();
            if (c == 0) begin b_if_req = 1; b_if_addr = 32'h4; end
            if (c == 4) b_if_req = 0;
            #1;
            chk($sformatf("lat1_ram_en_c%0d", c), {31'b0, b_ram_en}, {31'b0, c == 1});
            chk($sformatf("lat1_if_ready_c%0d", c), {31'b0, b_if_ready}, {31'b0, c == 3});
            if (c == 3) chk("lat1_if_rdata", b_if_rdata, 32'h00004444);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
